// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: shares one OBI slave port between NUM_MASTERS memory nodes.
// Unlocked requests are arbitrated round-robin; a request presented to the bus
// without a grant stays locked until granted. An in-order ID FIFO routes
// rvalid/rdata (reads and writes alike) back to the issuing master.
//
// Build option: define OBI_ARB_FIXED_PRIO_EN for fixed priority (lowest
// requesting index wins when unlocked, no rotation register).
//
// Bus layouts, per master and on the slave side:
//   request  [REQ_W-1:0]  = {req, we, be[3:0], addr[31:0], wdata[31:0]}
//   response [RESP_W-1:0] = {gnt, rvalid, rdata[31:0]}
// masters_req_i / masters_resp_o pack master i at slice [i*W +: W].
// NUM_MASTERS defaults to the node count of the standard CGRA build (4).

module obi_rr_arbiter #(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned ADDR_W = 32,
  localparam int unsigned DATA_W = 32,
  localparam int unsigned BE_W   = DATA_W / 8,
  localparam int unsigned REQ_W  = 2 + BE_W + ADDR_W + DATA_W,
  localparam int unsigned RESP_W = 2 + DATA_W
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_MASTERS*REQ_W-1:0]    masters_req_i,
  output logic [NUM_MASTERS*RESP_W-1:0]   masters_resp_o,
  output logic [REQ_W-1:0]                slave_req_o,
  input  logic [RESP_W-1:0]               slave_resp_i,
  output logic                            busy_o,
  output logic                            stall_o,
  output logic                            protocol_err_o
);

  localparam int unsigned IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_MASTERS - 1);
  localparam logic [PW-1:0]  LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(MAX_OUTSTANDING);

  // Unpacked view of the master request buses
  logic [REQ_W-1:0]       m_bus [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] m_req;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign m_bus[g] = masters_req_i[g*REQ_W +: REQ_W];
    assign m_req[g] = masters_req_i[g*REQ_W + REQ_W - 1];
  end

  logic              s_gnt;
  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata;

  assign s_gnt    = slave_resp_i[RESP_W-1];
  assign s_rvalid = slave_resp_i[RESP_W-2];
  assign s_rdata  = slave_resp_i[DATA_W-1:0];

  // State
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           perr_q, perr_d;

  logic [IDW-1:0] scan_id;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] head_id;
  logic           full;
  logic           empty;
  logic           slv_req;
  logic           xfer;
  logic           pop;

`ifdef OBI_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest requesting index wins
  always_comb begin
    logic found;
    found   = 1'b0;
    scan_id = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!found && m_req[IDW'(i)]) begin
        found   = 1'b1;
        scan_id = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] rr_q, rr_d;

  // Round-robin: first requester at or after rr_q, wrapping modulo NUM_MASTERS
  always_comb begin
    logic        found;
    int unsigned idx;
    found   = 1'b0;
    idx     = '0;
    scan_id = rr_q;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && m_req[IDW'(idx)]) begin
        found   = 1'b1;
        scan_id = IDW'(idx);
      end
    end
  end

  // Rotation pointer advances past the master just granted
  always_comb begin
    rr_d = rr_q;
    if (xfer) rr_d = (winner == LAST_ID) ? '0 : winner + IDW'(1);
  end

  // Rotation pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`endif

  assign winner  = lock_q ? lock_id_q : scan_id;
  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign head_id = fifo_q[rd_ptr_q];

  // Full blocks issue even when a pop happens in the same cycle
  assign slv_req = rst_ni & m_req[winner] & ~full;
  assign xfer    = slv_req & s_gnt;
  assign pop     = rst_ni & s_rvalid & ~empty;

  logic [NUM_MASTERS-1:0] gnt_vec;
  logic [NUM_MASTERS-1:0] rvalid_vec;
  logic [DATA_W-1:0]      rdata_bc;

  // Per-master grant and response strobes
  always_comb begin
    gnt_vec    = '0;
    rvalid_vec = '0;
    if (xfer) gnt_vec[winner]     = 1'b1;
    if (pop)  rvalid_vec[head_id] = 1'b1;
  end

  assign rdata_bc = rst_ni ? s_rdata : '0;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_resp
    assign masters_resp_o[g*RESP_W +: RESP_W] = {gnt_vec[g], rvalid_vec[g], rdata_bc};
  end

  assign slave_req_o    = rst_ni ? {slv_req, m_bus[winner][REQ_W-2:0]} : '0;
  assign stall_o        = rst_ni & (|m_req) & ~xfer;
  assign busy_o         = ~empty;
  assign protocol_err_o = perr_q;

  // Next state: lock tracking, ID FIFO pointers/count, sticky protocol error
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    perr_d    = perr_q | (s_rvalid & empty);

    if (xfer) begin
      lock_d = 1'b0;
    end else if (slv_req) begin
      lock_d    = 1'b1;
      lock_id_d = winner;
    end

    if (xfer) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);

    case ({xfer, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers and ID FIFO storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      perr_q    <= 1'b0;
      fifo_q    <= '{default: '0};
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      perr_q    <= perr_d;
      if (xfer) fifo_q[wr_ptr_q] <= winner;
    end
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Bench for obi_rr_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.

module tb_obi_rr_arbiter;

  localparam int N   = 4;
  localparam int M   = 2;
  localparam int RQW = 70;
  localparam int RSW = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [N*RQW-1:0] mreq_bus;
  logic [N*RSW-1:0] mresp_bus;
  logic [RQW-1:0]   sreq_bus;
  logic [RSW-1:0]   sresp_bus;
  logic             busy, stall, perr;

  obi_rr_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(M)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .masters_req_i (mreq_bus),
    .masters_resp_o(mresp_bus),
    .slave_req_o   (sreq_bus),
    .slave_resp_i  (sresp_bus),
    .busy_o        (busy),
    .stall_o       (stall),
    .protocol_err_o(perr)
  );

  // Stimulus
  bit          rst;
  bit [N-1:0]  mreq;
  logic [31:0] maddr  [N];
  logic [31:0] mwdata [N];
  logic        mwe    [N];
  logic [3:0]  mbe    [N];
  bit          sgnt, srv;
  logic [31:0] srdata;

  // Reference model: rotation start, lock, ordered queue of outstanding IDs
  int rr;
  bit lk;
  int lk_id;
  int q[$];
  bit mperr;

  // Observed values for directed checks
  logic [N-1:0] obs_gnt, obs_rv;
  logic         obs_sreq;
  logic [31:0]  obs_saddr;
  logic         obs_busy;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check #1 later, advance model
  task automatic step();
    int          win, start, c;
    bit          esreq, exfer, epop, ebusy, estall;
    logic [N-1:0]     egnt, erv;
    logic [N*RSW-1:0] eresp;
    @(negedge clk);
    rst_n = rst;
    for (int i = 0; i < N; i++)
      mreq_bus[i*RQW +: RQW] = {mreq[i], mwe[i], mbe[i], maddr[i], mwdata[i]};
    sresp_bus = {sgnt, srv, srdata};
    #1;
    if (!rst) begin
      rr = 0; lk = 0; q.delete(); mperr = 0;
    end
`ifdef OBI_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = rr;
`endif
    if (lk) begin
      win = lk_id;
    end else begin
      win = start;
      for (int k = N - 1; k >= 0; k--) begin
        c = (start + k) % N;
        if (mreq[c]) win = c;
      end
    end
    esreq  = rst && mreq[win] && (q.size() < M);
    exfer  = esreq && sgnt;
    epop   = rst && srv && (q.size() > 0);
    egnt   = '0;
    erv    = '0;
    if (exfer) egnt[win] = 1'b1;
    if (epop)  erv[q[0]] = 1'b1;
    for (int i = 0; i < N; i++)
      eresp[i*RSW +: RSW] = {egnt[i], erv[i], rst ? srdata : 32'h0};
    ebusy  = q.size() > 0;
    estall = rst && (mreq != '0) && !exfer;

    for (int i = 0; i < N; i++) begin
      obs_gnt[i] = mresp_bus[i*RSW + RSW - 1];
      obs_rv[i]  = mresp_bus[i*RSW + RSW - 2];
    end
    obs_sreq  = sreq_bus[RQW-1];
    obs_saddr = sreq_bus[63:32];
    obs_busy  = busy;

    chk("gnt", obs_gnt, egnt);
    chk("rvalid", obs_rv, erv);
    chk("resp_bus", mresp_bus, eresp);
    chk("slv_req", obs_sreq, esreq);
    if (esreq) chk("slv_bus", sreq_bus, {1'b1, mwe[win], mbe[win], maddr[win], mwdata[win]});
    if (!rst)  chk("slv_bus_rst", sreq_bus, '0);
    chk("busy", busy, ebusy);
    chk("stall", stall, estall);
    chk("perr", perr, mperr);

    if (rst) begin
      if (srv && q.size() == 0) mperr = 1;
      if (epop) void'(q.pop_front());
      if (exfer) begin
        q.push_back(win);
        rr = (win + 1) % N;
        lk = 0;
        mreq[win] = 0;
      end else if (esreq) begin
        lk = 1;
        lk_id = win;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst = 0; mreq = '0; sgnt = 0; srv = 0; srdata = '0;
    step();
    step();
    rst = 1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] t1_exp [5];
    t1_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < N; i++) begin
      maddr[i]  = 32'h1000_0000 * (i + 1);
      mwdata[i] = $urandom;
      mwe[i]    = 1'b0;
      mbe[i]    = 4'hF;
    end
    rst_n = 0; mreq_bus = '0; sresp_bus = '0;
    do_reset();
    chk("rst_busy", obs_busy, 1'b0);
    chk("rst_sreq", obs_sreq, 1'b0);

    // 1: all masters requesting, rvalid one cycle after each grant
    for (int k = 0; k < 5; k++) begin
      mreq = '1; sgnt = 1; srv = (k > 0); srdata = 32'hD00D_0000 + 32'(k);
      step();
`ifndef OBI_ARB_FIXED_PRIO_EN
      chk("t1_gnt", obs_gnt, t1_exp[k]);
      if (k > 0) begin
        chk("t1_rv", obs_rv, t1_exp[k-1]);
        chk("t1_rdata", mresp_bus[((k-1)%N)*RSW +: 32], 32'hD00D_0000 + 32'(k));
      end
`endif
    end

    // 2: lock holds master 2 while master 0 joins
    do_reset();
    maddr[2] = 32'h2222_0000; maddr[0] = 32'h0000_1000;
    mreq = 4'b0100; sgnt = 0;
    step();
    chk("t2_addr0", obs_saddr, 32'h2222_0000);
    mreq = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t2_gnt_wait", obs_gnt, 4'b0000);
      chk("t2_addr", obs_saddr, 32'h2222_0000);
    end
    sgnt = 1;
    step();
    chk("t2_gnt_m2", obs_gnt, 4'b0100);
    step();
    chk("t2_gnt_m0", obs_gnt, 4'b0001);

    // 3: FIFO full blocks issue; a pop frees it for the next cycle
    do_reset();
    sgnt = 1; srv = 0;
    mreq = '1; step(); chk("t3_g1", obs_gnt, 4'b0001);
    mreq = '1; step(); chk("t3_g2", obs_gnt, 4'b0010);
    mreq = '1; step();
    chk("t3_full_req", obs_sreq, 1'b0);
    chk("t3_busy", obs_busy, 1'b1);
    srv = 1; srdata = 32'hAAAA_5555; mreq = '1; step();
    chk("t3_pop_rv", obs_rv, 4'b0001);
    chk("t3_pop_gnt", obs_gnt, 4'b0000);
    srv = 0; mreq = '1; step();
`ifndef OBI_ARB_FIXED_PRIO_EN
    chk("t3_regrant", obs_gnt, 4'b0100);
`else
    chk("t3_regrant", obs_gnt, 4'b0001);
`endif

    // 4: rvalid with empty FIFO sets a sticky error
    do_reset();
    srv = 1; step();
    chk("t4_no_rv", obs_rv, 4'b0000);
    srv = 0; step();
    chk("t4_perr", perr, 1'b1);
    step();
    chk("t4_perr_sticky", perr, 1'b1);
    rst = 0; step();
    chk("t4_perr_clr", perr, 1'b0);
    rst = 1;

    // 5: reset with two outstanding discards them
    do_reset();
    sgnt = 1;
    mreq = '1; step();
    mreq = '1; step();
    rst = 0; mreq = '1; srv = 1; step();
    chk("t5_busy", obs_busy, 1'b0);
    chk("t5_gnt", obs_gnt, 4'b0000);
    chk("t5_rv", obs_rv, 4'b0000);
    chk("t5_sreq", obs_sreq, 1'b0);
    rst = 1; srv = 0; mreq = '1; step();
    chk("t5_first_gnt", obs_gnt, 4'b0001);

`ifdef OBI_ARB_FIXED_PRIO_EN
    // 6: fixed priority starves master 3
    do_reset();
    for (int k = 0; k < 6; k++) begin
      mreq = 4'b1010; sgnt = 1; srv = (k > 0);
      step();
      chk("t6_gnt", obs_gnt, 4'b0010);
    end
`endif

    // Randomized traffic with occasional resets
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(299) != 0);
      for (int i = 0; i < N; i++) begin
        if (!mreq[i] && $urandom_range(2) == 0) begin
          mreq[i]   = 1;
          maddr[i]  = $urandom;
          mwdata[i] = $urandom;
          mwe[i]    = 1'($urandom_range(1));
          mbe[i]    = 4'($urandom_range(15));
        end
      end
      sgnt   = ($urandom_range(3) != 0);
      srv    = ($urandom_range(2) == 0);
      srdata = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
